// File: rtl/isqrt_pkg.sv
// Types and constants shared by the integer square root unit and its reconstruction checker.
package isqrt_pkg;

    localparam int ISQRT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/isqrt_recon.sv
// Rebuilds num = root*root + rem with an MSB-first shift-add multiplier and flags legal isqrt remainders.
module isqrt_recon
    import isqrt_pkg::*;
#(
    parameter int W = ISQRT_W
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [W-1:0]   root,
    input  logic [W:0]     rem,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] num,
    output logic           ovf,
    output logic           rem_ok
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IND_MAX = IW'(W - 1);

    state_t           state;
    logic [2*W-1:0]   acc;
    logic [IW-1:0]    ind;
    logic [W-1:0]     root_q;
    logic [W:0]       rem_q;
    logic [2*W:0]     sum;

    // One partial product per cycle; acc never exceeds root^2 so 2W bits suffice.
    function automatic logic [2*W-1:0] mac_step(input logic [2*W-1:0] a,
                                                 input logic [W-1:0]   r,
                                                 input logic [IW-1:0]  i);
        if (r[i])
            return a + ({{W{1'b0}}, r} << i);
        return a;
    endfunction

    function automatic logic [2*W:0] add_rem(input logic [2*W-1:0] a,
                                             input logic [W:0]     m);
        return {1'b0, a} + {{W{1'b0}}, m};
    endfunction

    assign sum = add_rem(acc, rem_q);

    // Operands are only meaningful after acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            root_q <= root;
            rem_q  <= rem;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            num       <= '0;
            ovf       <= 1'b0;
            rem_ok    <= 1'b0;
            acc       <= '0;
            ind       <= IND_MAX;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        ind      <= IND_MAX;
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc <= mac_step(acc, root_q, ind);
                    if (ind == '0)
                        state <= ADD;
                    else
                        ind <= ind - 1'b1;
                end
                ADD: begin
                    num       <= sum[2*W-1:0];
                    ovf       <= sum[2*W];
                    rem_ok    <= (rem_q <= {root_q, 1'b0});
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_recon.sv
// Randomized bench for isqrt_recon against an arithmetic model of root^2+rem and the rem<=2*root rule.
module tb_isqrt_recon;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic [W-1:0]   root;
    logic [W:0]     rem;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] num;
    logic           ovf;
    logic           rem_ok;

    int checks = 0;
    int errors = 0;

    isqrt_recon #(.W(W)) dut (
        .clk(clk), .clr(clr), .start(start), .root(root), .rem(rem),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .num(num), .ovf(ovf), .rem_ok(rem_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts one operation and returns once out_valid is seen; lat counts edges after acceptance.
    task automatic run_op(input logic [W-1:0] r, input logic [W:0] m, output int lat);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
        root  = r;
        rem   = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("accept_in_ready", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("done_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic op_vs_model(input string tag, input logic [W-1:0] r, input logic [W:0] m);
        longint unsigned s;
        int lat;
        s = longint'(r) * longint'(r) + longint'(m);
        run_op(r, m, lat);
        check({tag, "_num"}, 64'(num), s & 64'hFFFF_FFFF);
        check({tag, "_ovf"}, 64'(ovf), (s >> 32) & 64'd1);
        check({tag, "_rem_ok"}, 64'(rem_ok), 64'(longint'(m) <= 2 * longint'(r)));
        drain();
    endtask

    function automatic longint unsigned model_isqrt(input longint unsigned v);
        longint unsigned s;
        s = longint'($sqrt(real'(v)));
        while (s * s > v) s--;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    initial begin
        int lat;
        logic [2*W-1:0] held_num;
        logic held_ovf, held_rem_ok;
        logic [31:0] v;
        longint unsigned s;

        clr = 1'b1; start = 1'b0; out_ready = 1'b0; root = '0; rem = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_num", 64'(num), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_rem_ok", 64'(rem_ok), 64'd0);
        @(negedge clk);
        clr = 1'b0;

        run_op(16'd0, 17'd0, lat);
        check("zero_latency", 64'(lat), 64'd17);
        check("zero_num", 64'(num), 64'd0);
        check("zero_ovf", 64'(ovf), 64'd0);
        check("zero_rem_ok", 64'(rem_ok), 64'd1);
        drain();

        op_vs_model("r12345", 16'd12345, 17'd100);
        check("r12345_fixed", 64'(num), 64'd152399125);
        op_vs_model("max_fit", 16'd65535, 17'd131070);
        check("max_fit_fixed", 64'(num), 64'd4294967295);
        op_vs_model("max_ovf", 16'd65535, 17'd131071);
        check("max_ovf_fixed", 64'(ovf), 64'd1);
        op_vs_model("r3", 16'd3, 17'd7);
        check("r3_fixed", 64'(num), 64'd16);

        // Back-pressure: result held while start pulses are ignored.
        run_op(16'd1000, 17'd77, lat);
        held_num = num; held_ovf = ovf; held_rem_ok = rem_ok;
        check("bp_num", 64'(held_num), 64'd1000077);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
            root  = 16'($urandom);
            rem   = 17'($urandom);
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_num", 64'(num), 64'(held_num));
            check("bp_hold_flags", {62'd0, ovf, rem_ok}, {62'd0, held_ovf, held_rem_ok});
        end
        @(negedge clk);
        start = 1'b0;
        drain();
        check("bp_num_kept", 64'(num), 64'(held_num));

        // Abort mid-multiply.
        @(negedge clk);
        root = 16'd40000; rem = 17'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_in_ready", 64'(in_ready), 64'd1);
        check("clr_num", 64'(num), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 check("clr_no_result", 64'(out_valid), 64'd0);
        end
        op_vs_model("after_clr", 16'd2, 17'd1);
        check("after_clr_fixed", 64'(num), 64'd5);

        for (int i = 0; i < 100; i++)
            op_vs_model("rand", 16'($urandom), 17'($urandom_range(0, 131071)));

        // Round trip through an integer square root.
        for (int i = 0; i < 1000; i++) begin
            v = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'd0 : $urandom;
            s = model_isqrt(64'(v));
            run_op(16'(s), 17'(64'(v) - s * s), lat);
            check("rt_num", 64'(num), 64'(v));
            check("rt_ovf", 64'(ovf), 64'd0);
            check("rt_rem_ok", 64'(rem_ok), 64'd1);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
